// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and helpers for the 1RW SRAM arbiter
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } grant_e;

    localparam int RSP_DEPTH = 2;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - 2-entry first-word-fall-through buffer for read responses
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [WIDTH-1:0] mem_d [RSP_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    // Callers guarantee no push while full and no pop while empty.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_valid = (count_q != 2'd0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;

endmodule

// File: rtl/sram_1rw_arbiter.sv
// rtl/sram_1rw_arbiter.sv - shares one 1RW SRAM macro between a read and a write requester
module sram_1rw_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 2848,
    parameter int WORD_DEPTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int MAX_WR_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr,
    output logic                  rd_rsp_valid,
    input  logic                  rd_rsp_ready,
    output logic [DATA_WIDTH-1:0] rd_rsp_data,
    output logic                  rd_rsp_err,
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [DATA_WIDTH-1:0] wr_req_data,
    input  logic [DATA_WIDTH-1:0] wr_req_mask,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wd,
    output logic [DATA_WIDTH-1:0] sram_w_mask,
    input  logic [DATA_WIDTH-1:0] sram_rd
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_WR_BURST);

    grant_e              gnt;
    logic                rd_inflight_q, rd_inflight_d;
    logic                rd_err_q, rd_err_d;
    logic [3:0]          wr_streak_q, wr_streak_d;
    logic [1:0]          occ;
    logic                rsp_pop, rd_ok, rd_in_range, wr_in_range;
    logic [DATA_WIDTH-1:0] rd_data_sel;
    logic [DATA_WIDTH:0]   push_word, head_word;

    assign rsp_pop     = rd_rsp_valid & rd_rsp_ready;
    assign rd_ok       = (({1'b0, occ} + {2'b0, rd_inflight_q}) - {2'b0, rsp_pop}) < 3'd2;
    assign rd_in_range = addr_in_range(32'(rd_req_addr), 32'(WORD_DEPTH));
    assign wr_in_range = addr_in_range(32'(wr_req_addr), 32'(WORD_DEPTH));

    // Reset gates the grant so no handshake or macro access escapes while rst_n is low.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst_n) begin
            gnt = GNT_NONE;
        end else if (wr_req_valid && rd_req_valid) begin
            gnt = ((wr_streak_q < BURST_MAX) || !rd_ok) ? GNT_WR : GNT_RD;
        end else if (wr_req_valid) begin
            gnt = GNT_WR;
        end else if (rd_req_valid && rd_ok) begin
            gnt = GNT_RD;
        end
    end

    always_comb begin
        rd_req_ready = 1'b0;
        wr_req_ready = 1'b0;
        sram_ce      = 1'b0;
        sram_we      = 1'b0;
        sram_addr    = '0;
        sram_wd      = '0;
        sram_w_mask  = '0;
        case (gnt)
            GNT_WR: begin
                wr_req_ready = 1'b1;
                sram_ce      = wr_in_range;
                sram_we      = 1'b1;
                sram_addr    = wr_req_addr;
                sram_wd      = wr_req_data;
                sram_w_mask  = wr_req_mask;
            end
            GNT_RD: begin
                rd_req_ready = 1'b1;
                sram_ce      = rd_in_range;
                sram_addr    = rd_req_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_inflight_d = (gnt == GNT_RD);
        rd_err_d      = (gnt == GNT_RD) && !rd_in_range;
        wr_streak_d   = wr_streak_q;
        if (!rd_req_valid || gnt == GNT_RD) begin
            wr_streak_d = 4'd0;
        end else if (gnt == GNT_WR && wr_streak_q < BURST_MAX) begin
            wr_streak_d = wr_streak_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_inflight_q <= 1'b0;
            rd_err_q      <= 1'b0;
            wr_streak_q   <= 4'd0;
        end else begin
            rd_inflight_q <= rd_inflight_d;
            rd_err_q      <= rd_err_d;
            wr_streak_q   <= wr_streak_d;
        end
    end

    assign rd_data_sel = rd_err_q ? '0 : sram_rd;
    assign push_word   = {rd_err_q, rd_data_sel};

    sram_rsp_fifo #(.WIDTH(DATA_WIDTH + 1)) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (rd_inflight_q),
        .push_data  (push_word),
        .pop        (rsp_pop),
        .head_data  (head_word),
        .head_valid (rd_rsp_valid),
        .count      (occ)
    );

    assign rd_rsp_err  = head_word[DATA_WIDTH];
    assign rd_rsp_data = head_word[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// tb/tb_sram_1rw_arbiter.sv - directed and random checks of sram_1rw_arbiter against a shadow memory model
module tb_sram_1rw_arbiter;

    localparam int DW    = 2848;
    localparam int AW    = 6;
    localparam int DEPTH = 32;
    localparam int BURST = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_req_valid = 1'b0, rd_req_ready;
    logic [AW-1:0] rd_req_addr = '0;
    logic          rd_rsp_valid, rd_rsp_ready = 1'b1, rd_rsp_err;
    logic [DW-1:0] rd_rsp_data;
    logic          wr_req_valid = 1'b0, wr_req_ready;
    logic [AW-1:0] wr_req_addr = '0;
    logic [DW-1:0] wr_req_data = '0, wr_req_mask = '0;
    logic          sram_ce, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wd, sram_w_mask;
    logic [DW-1:0] sram_rd = '0;

    logic [DW-1:0] smem    [DEPTH] = '{default: '0};
    logic [DW-1:0] ref_mem [DEPTH] = '{default: '0};
    logic [DW:0]   exp_q [$];
    logic [DW:0]   last_rsp = '0;
    logic          rd_acc, wr_acc;
    int            total = 0, bad = 0;
    int            last_gnt = 0, n_rsp = 0, k = 0, base = 0;
    logic [DW-1:0] pattern, ones_lo16;

    always #5 clk = ~clk;

    sram_1rw_arbiter #(
        .DATA_WIDTH(DW), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(AW), .MAX_WR_BURST(BURST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
        .rd_rsp_data(rd_rsp_data), .rd_rsp_err(rd_rsp_err),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
        .wr_req_data(wr_req_data), .wr_req_mask(wr_req_mask),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wd(sram_wd), .sram_w_mask(sram_w_mask), .sram_rd(sram_rd)
    );

    // Behavioural 1RW macro: read data appears the cycle after the access.
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we)
                smem[sram_addr[4:0]] <= (smem[sram_addr[4:0]] & ~sram_w_mask) | (sram_wd & sram_w_mask);
            else
                sram_rd <= smem[sram_addr[4:0]];
        end
    end

    task automatic chk_w(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        int d;
        d = -1;
        total++;
        if (obs !== exp)
            for (int i = DW; i >= 0; i--) if (obs[i] !== exp[i]) d = i;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs_lo=%h exp_lo=%h first_diff_bit=%0d", tag, obs[63:0], exp[63:0], d);
        end
    endtask

    task automatic chk_n(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] v;
        for (int i = 0; i < DW; i += 32) v[i +: 32] = $urandom;
        return v;
    endfunction

    // Observe handshakes mid-cycle, update the shadow memory and expected response queue.
    task automatic cycle();
        @(negedge clk);
        rd_acc   = rd_req_valid && rd_req_ready;
        wr_acc   = wr_req_valid && wr_req_ready;
        last_gnt = wr_acc ? 2 : (rd_acc ? 1 : 0);
        if (rd_acc && wr_acc) chk_n("single_grant", 32'(rd_acc && wr_acc), 0);
        if (wr_acc) begin
            chk_n("wr_ce", 32'(sram_ce), 32'(wr_req_addr < DEPTH));
            chk_n("wr_we", 32'(sram_we), 1);
            if (wr_req_addr < DEPTH)
                ref_mem[wr_req_addr[4:0]] = (ref_mem[wr_req_addr[4:0]] & ~wr_req_mask) | (wr_req_data & wr_req_mask);
        end
        if (rd_acc) begin
            chk_n("rd_ce", 32'(sram_ce), 32'(rd_req_addr < DEPTH));
            chk_n("rd_we", 32'(sram_we), 0);
            if (rd_req_addr < DEPTH) exp_q.push_back({1'b0, ref_mem[rd_req_addr[4:0]]});
            else                     exp_q.push_back({1'b1, {DW{1'b0}}});
        end
        if (rd_rsp_valid && rd_rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) chk_n("rsp_unexpected", 1, 0);
            else begin
                last_rsp = {rd_rsp_err, rd_rsp_data};
                chk_w("rsp_data", last_rsp, exp_q.pop_front());
            end
        end
        if (exp_q.size() > 2) chk_n("credit_outstanding", 32'(exp_q.size()), 2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        pattern   = {356{8'hA5}};
        ones_lo16 = '0;
        ones_lo16[15:0] = 16'hFFFF;

        // Reset: both requesters valid but nothing may be acknowledged.
        rd_req_valid = 1'b1; wr_req_valid = 1'b1; rd_req_addr = 6'd3; wr_req_addr = 6'd3;
        #2;
        chk_n("rst_rd_ready", 32'(rd_req_ready), 0);
        chk_n("rst_wr_ready", 32'(wr_req_ready), 0);
        chk_n("rst_ce", 32'(sram_ce), 0);
        chk_n("rst_we", 32'(sram_we), 0);
        chk_n("rst_rsp_valid", 32'(rd_rsp_valid), 0);
        chk_w("rst_rsp", {rd_rsp_err, rd_rsp_data}, '0);
        cycle();
        rd_req_valid = 1'b0; wr_req_valid = 1'b0;
        rst_n = 1'b1;
        cycle();

        // Full write then read of addr 3 with latency check.
        wr_req_valid = 1'b1; wr_req_addr = 6'd3; wr_req_data = pattern; wr_req_mask = '1;
        #1;
        chk_n("t1_wr_ce_we", {30'd0, sram_ce, sram_we}, 32'd3);
        chk_n("t1_wr_addr", 32'(sram_addr), 3);
        chk_w("t1_wr_wd", {1'b0, sram_wd}, {1'b0, pattern});
        cycle();
        wr_req_valid = 1'b0; rd_req_valid = 1'b1; rd_req_addr = 6'd3;
        #1;
        chk_n("t1_rd_ce_we", {30'd0, sram_ce, sram_we}, 32'd2);
        cycle();
        rd_req_valid = 1'b0;
        chk_n("t1_lat_t1", 32'(rd_rsp_valid), 0);
        cycle();
        chk_n("t1_lat_t2", 32'(rd_rsp_valid), 1);
        chk_w("t1_data", {rd_rsp_err, rd_rsp_data}, {1'b0, pattern});
        cycle();

        // Masked write of the low 16 bits onto a zero word.
        wr_req_valid = 1'b1; wr_req_addr = 6'd5; wr_req_data = '0; wr_req_mask = '1;
        cycle();
        wr_req_data = '1; wr_req_mask = ones_lo16;
        cycle();
        wr_req_valid = 1'b0; rd_req_valid = 1'b1; rd_req_addr = 6'd5;
        cycle();
        rd_req_valid = 1'b0;
        repeat (2) cycle();
        chk_w("t2_masked", last_rsp, {1'b0, ones_lo16});

        // Both requesters saturated: W,W,W,W,R repeating.
        wr_req_valid = 1'b1; rd_req_valid = 1'b1; wr_req_mask = '1;
        for (int i = 0; i < 15; i++) begin
            wr_req_addr = 6'($urandom_range(0, DEPTH - 1));
            rd_req_addr = 6'($urandom_range(0, DEPTH - 1));
            wr_req_data = rnd_word();
            cycle();
            chk_n("t3_grant", 32'(last_gnt), (i % 5 == 4) ? 32'd1 : 32'd2);
        end
        wr_req_valid = 1'b0; rd_req_valid = 1'b0;
        repeat (3) cycle();

        // Backpressure: only two reads may be outstanding.
        wr_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_req_addr = 6'(10 + i); wr_req_data = rnd_word();
            cycle();
        end
        wr_req_valid = 1'b0; rd_rsp_ready = 1'b0; rd_req_valid = 1'b1; k = 0;
        base = n_rsp;
        for (int i = 0; i < 6; i++) begin
            rd_req_addr = 6'(10 + k);
            cycle();
            if (rd_acc) k++;
        end
        chk_n("t4_accepted", 32'(k), 2);
        chk_n("t4_blocked", 32'(rd_req_ready), 0);
        rd_rsp_ready = 1'b1;
        for (int i = 0; i < 30 && (n_rsp - base) < 5; i++) begin
            rd_req_valid = (k < 5);
            rd_req_addr  = 6'(10 + k);
            cycle();
            if (rd_acc) k++;
        end
        rd_req_valid = 1'b0;
        chk_n("t4_all_accepted", 32'(k), 5);
        chk_n("t4_all_drained", 32'(n_rsp - base), 5);

        // Out-of-range read and write.
        rd_req_valid = 1'b1; rd_req_addr = 6'd40;
        #1;
        chk_n("t5_rd_oor", {30'd0, rd_req_ready, sram_ce}, 32'd2);
        cycle();
        rd_req_valid = 1'b0;
        repeat (2) cycle();
        chk_w("t5_rd_err", last_rsp, {1'b1, {DW{1'b0}}});
        wr_req_valid = 1'b1; wr_req_addr = 6'd40; wr_req_data = '1;
        #1;
        chk_n("t5_wr_oor", {30'd0, wr_req_ready, sram_ce}, 32'd2);
        cycle();
        wr_req_valid = 1'b0;

        // Reset one cycle after a read accept discards it.
        rd_req_valid = 1'b1; rd_req_addr = 6'd3;
        cycle();
        rst_n = 1'b0;
        #1;
        chk_n("t6_rst_ready", {30'd0, rd_req_ready, sram_ce}, 0);
        chk_n("t6_rst_rsp", 32'(rd_rsp_valid), 0);
        exp_q.delete();
        base = n_rsp;
        cycle();
        rst_n = 1'b1; rd_req_valid = 1'b0;
        repeat (4) cycle();
        chk_n("t6_no_rsp", 32'(n_rsp - base), 0);
        wr_req_valid = 1'b1; wr_req_addr = 6'd7; wr_req_data = rnd_word(); wr_req_mask = '1;
        cycle();
        wr_req_valid = 1'b0; rd_req_valid = 1'b1; rd_req_addr = 6'd7;
        cycle();
        rd_req_valid = 1'b0;
        repeat (2) cycle();
        chk_n("t6_resume", 32'(n_rsp - base), 1);

        // Random traffic against the shadow model.
        for (int i = 0; i < 300; i++) begin
            rd_req_valid = ($urandom % 4) != 0;
            wr_req_valid = ($urandom % 2) != 0;
            rd_req_addr  = 6'($urandom_range(0, 35));
            wr_req_addr  = 6'($urandom_range(0, 35));
            wr_req_data  = rnd_word();
            wr_req_mask  = ($urandom % 2) ? '1 : rnd_word();
            rd_rsp_ready = ($urandom % 4) != 0;
            cycle();
        end
        rd_req_valid = 1'b0; wr_req_valid = 1'b0; rd_rsp_ready = 1'b1;
        repeat (6) cycle();
        chk_n("rand_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_1rw_arbiter.md
Name: sram_1rw_arbiter

Overview:
- Shares one single-port (1RW) wide SRAM macro between an independent read requester and an independent write requester, each with valid/ready handshakes.
- Write requests have priority, bounded so reads cannot starve.
- Read data is returned through a 2-entry response buffer. Read issue is gated by credits so the buffer never overflows and back-to-back reads sustain one per cycle.
- Sits between the cache/table pipeline logic and the sram_NxM_1rw macro instances.

Parameters:
- DATA_WIDTH, 2848, word width; matches the macro BITS.
- WORD_DEPTH, 32, number of words.
- ADDR_WIDTH, 5, address width; WORD_DEPTH must be <= 2^ADDR_WIDTH.
- MAX_WR_BURST, 4, consecutive write grants allowed while a read is pending (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_req_valid  in  1  read request valid.
- rd_req_ready  out  1  read request accepted this cycle.
- rd_req_addr  in  ADDR_WIDTH  read address.
- rd_rsp_valid  out  1  head of response buffer valid.
- rd_rsp_ready  in  1  consumer takes the head entry.
- rd_rsp_data  out  DATA_WIDTH  read data.
- rd_rsp_err  out  1  address was >= WORD_DEPTH; data is all zeros.
- wr_req_valid  in  1  write request valid.
- wr_req_ready  out  1  write request accepted this cycle.
- wr_req_addr  in  ADDR_WIDTH  write address.
- wr_req_data  in  DATA_WIDTH  write data.
- wr_req_mask  in  DATA_WIDTH  per-bit write enable; 1 = write the bit.
- sram_ce  out  1  macro chip enable.
- sram_we  out  1  macro write enable.
- sram_addr  out  ADDR_WIDTH  macro address.
- sram_wd  out  DATA_WIDTH  macro write data.
- sram_w_mask  out  DATA_WIDTH  macro bit mask.
- sram_rd  in  DATA_WIDTH  macro read data, valid the cycle after a read access.

Behaviour:
- Single clock clk; reset rst_n is asynchronous, active-low.
- Reset state:
  - Response buffer empty, rd_inflight=0, wr_streak=0.
  - rd_rsp_valid=0, rd_rsp_data=0, rd_rsp_err=0.
  - rd_req_ready=0, wr_req_ready=0, sram_ce=0, sram_we=0 while rst_n is low.
- Grant decision is combinational each cycle: GNT_WR, GNT_RD or GNT_NONE.
- Read credit: rd_ok = (occupancy + rd_inflight - (rd_rsp_valid & rd_rsp_ready)) < 2.
- Arbitration:
  - Write-only pending -> GNT_WR.
  - Read-only pending with rd_ok -> GNT_RD.
  - Both pending:
    - GNT_WR if wr_streak < MAX_WR_BURST or !rd_ok.
    - Otherwise GNT_RD.
- wr_streak:
  - Increments on GNT_WR while rd_req_valid is high.
  - Clears on GNT_RD or when rd_req_valid is low.
  - Saturates at MAX_WR_BURST.
- GNT_WR:
  - wr_req_ready=1.
  - sram_ce=1, sram_we=1, sram_addr/sram_wd/sram_w_mask driven from the request in the same cycle.
  - Address >= WORD_DEPTH: sram_ce=0; the write is silently dropped but still acknowledged.
- GNT_RD:
  - rd_req_ready=1, sram_ce=1, sram_we=0.
  - rd_inflight set for the next cycle, together with an err tag (address >= WORD_DEPTH).
  - If the err tag is set, sram_ce=0.
- Cycle after GNT_RD: push into the response buffer either sram_rd, or zeros with err=1 when the tag is set. rd_inflight clears unless a new read was granted.
- Ordering: accesses take effect in grant order. A read granted in the cycle after a write to the same address returns the new data.
- Response buffer:
  - 2-entry FIFO, first-word fall-through.
  - Simultaneous push and pop when full is legal.
  - Credit logic guarantees no push while full.
  - Occupancy never exceeds 2.
- Latency:
  - Read request accepted at T -> rd_rsp_valid at T+2 if the buffer was empty.
  - Sustained read throughput is 1 per cycle when rd_rsp_ready stays high.
- When GNT_NONE: sram_ce=0, other SRAM outputs hold don't-care (drive 0).
- Reset asserted mid-operation: in-flight read discarded, buffer flushed, no SRAM access in the reset cycle.

Decomposition:
- Package sram_ctrl_pkg:
  - grant enum GNT_NONE/GNT_RD/GNT_WR.
  - Localparam RSP_DEPTH=2.
  - Function addr_in_range(addr).
- One sub-module, sram_rsp_fifo: 2-entry FFWT buffer of {err, data} with push/pop/count.
- Arbitration, credit counter and streak counter stay in the top module.

Test Plan:
- Write addr 3, data 0xA5 pattern, mask all-ones; then read addr 3 -> sram_ce/sram_we=1/1 then 1/0; rd_rsp_data = pattern, 2 cycles after read accept.
- Masked write: mask low 16 bits only, data 0xFFFF... onto a word of 0 -> read returns 0x0000FFFF in the low word, upper bits 0.
- Reads and writes both continuously valid, MAX_WR_BURST=4 -> grant pattern W,W,W,W,R repeating; no read waits more than 5 cycles.
- rd_rsp_ready=0, 5 reads valid -> exactly 2 accepted, rd_req_ready stays 0 afterwards; raise ready -> remaining reads drain in order with no loss or duplication.
- Read addr 40 with WORD_DEPTH=32 -> sram_ce=0 that cycle; response has err=1 and data 0. Write to addr 40 -> acknowledged, no macro access.
- Assert rst_n low one cycle after a read accept -> no response ever appears; all outputs are at reset values asynchronously; normal operation resumes after release.
